// File: rtl/branch_pkg.sv
// Shared encodings and defaults for the branch controller and its return stack.
package branch_pkg;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_CALL   = 3'd2,
        OP_RET    = 3'd3,
        OP_BRCOND = 3'd4,
        OP_RETI   = 3'd5,
        OP_EI     = 3'd6,
        OP_DI     = 3'd7
    } op_e;

    localparam int unsigned ADDR_W            = 12;
    localparam int unsigned DEF_STACK_DEPTH   = 8;
    localparam logic [ADDR_W-1:0] DEF_INT_VECTOR = 12'h004;

    // Return address of an instruction; wraps naturally at the top of the 12-bit space.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/branch_ctrl_ret_stack.sv
// LIFO return-address stack; only the pointer is reset, storage is left as-is.
module ret_stack
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_ptr;
    logic [AW-1:0]     w_top_idx;
    logic [AW-1:0]     w_wr_idx;

    assign full      = (r_ptr == PW'(DEPTH));
    assign empty     = (r_ptr == '0);
    assign w_top_idx = AW'(r_ptr - PW'(1));
    assign w_wr_idx  = AW'(r_ptr);
    assign top       = empty ? '0 : r_mem[w_top_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (push && !full) begin
            r_ptr <= r_ptr + PW'(1);
        end else if (pop && !empty) begin
            r_ptr <= r_ptr - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/call/return and interrupt-entry redirect logic with a hardware return stack.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned       STACK_DEPTH = DEF_STACK_DEPTH,
    parameter logic [ADDR_W-1:0] INT_VECTOR  = DEF_INT_VECTOR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              kill,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [ADDR_W-1:0] op_pc,
    input  logic [ADDR_W-1:0] op_target,
    input  logic              cond,
    input  logic              irq,
    input  logic              clr_err,
    output logic              goto,
    output logic [ADDR_W-1:0] goto_addr,
    output logic              int_en,
    output logic              int_active,
    output logic              stack_ovf,
    output logic              stack_unf
);

    logic              r_int_en;
    logic              r_int_active;
    logic              r_ovf;
    logic              r_unf;

    logic              w_live;
    op_e               w_op;
    logic              w_goto;
    logic [ADDR_W-1:0] w_addr;
    logic              w_push;
    logic              w_pop;
    logic              w_take_int;
    logic              w_reti;
    logic              w_ei;
    logic              w_di;
    logic [ADDR_W-1:0] w_top;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf_evt;
    logic              w_unf_evt;

    assign w_live = op_valid & ~kill;
    assign w_op   = op_e'(op_code);

    always_comb begin
        w_goto     = 1'b0;
        w_addr     = '0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_take_int = 1'b0;
        w_reti     = 1'b0;
        w_ei       = 1'b0;
        w_di       = 1'b0;
        if (w_live) begin
            case (w_op)
                OP_NONE: begin
                    // Interrupts are only accepted on an empty slot so no real op is lost.
                    if (irq && r_int_en && !r_int_active) begin
                        w_goto     = 1'b1;
                        w_addr     = INT_VECTOR;
                        w_push     = 1'b1;
                        w_take_int = 1'b1;
                    end
                end
                OP_JUMP: begin
                    w_goto = 1'b1;
                    w_addr = op_target;
                end
                OP_CALL: begin
                    w_goto = 1'b1;
                    w_addr = op_target;
                    w_push = 1'b1;
                end
                OP_RET: begin
                    w_goto = 1'b1;
                    w_addr = w_top;
                    w_pop  = 1'b1;
                end
                OP_BRCOND: begin
                    w_goto = cond;
                    w_addr = op_target;
                end
                OP_RETI: begin
                    w_goto = 1'b1;
                    w_addr = w_top;
                    w_pop  = 1'b1;
                    w_reti = 1'b1;
                end
                OP_EI:   w_ei = 1'b1;
                OP_DI:   w_di = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_ovf_evt = w_push & ~pause & w_full;
    assign w_unf_evt = w_pop  & ~pause & w_empty;

    ret_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push & ~pause),
        .pop       (w_pop & ~pause),
        .push_data (next_pc(op_pc)),
        .top       (w_top),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_int_en     <= 1'b0;
            r_int_active <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else begin
            if (!pause) begin
                if (w_ei) begin
                    r_int_en <= 1'b1;
                end else if (w_di) begin
                    r_int_en <= 1'b0;
                end
                if (w_take_int) begin
                    r_int_active <= 1'b1;
                end else if (w_reti) begin
                    r_int_active <= 1'b0;
                end
            end
            // Error events are already gated by pause; clr_err acts regardless and loses to a new event.
            r_ovf <= w_ovf_evt | (r_ovf & ~clr_err);
            r_unf <= w_unf_evt | (r_unf & ~clr_err);
        end
    end

    assign goto       = w_goto;
    assign goto_addr  = w_addr;
    assign int_en     = r_int_en;
    assign int_active = r_int_active;
    assign stack_ovf  = r_ovf;
    assign stack_unf  = r_unf;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_branch_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam logic [11:0] IVEC  = 12'h004;

    localparam logic [2:0] C_NONE = 3'd0, C_JUMP = 3'd1, C_CALL = 3'd2, C_RET = 3'd3,
                           C_BRC  = 3'd4, C_RETI = 3'd5, C_EI   = 3'd6, C_DI  = 3'd7;

    logic        clk = 1'b0;
    logic        reset, pause, kill, op_valid, cond, irq, clr_err;
    logic [2:0]  op_code;
    logic [11:0] op_pc, op_target;
    logic        goto, int_en, int_active, stack_ovf, stack_unf;
    logic [11:0] goto_addr;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // reference model state
    logic [11:0] m_stk[$];
    bit m_ie, m_ia, m_ovf, m_unf;

    branch_ctrl #(
        .STACK_DEPTH (DEPTH),
        .INT_VECTOR  (IVEC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .kill       (kill),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_pc      (op_pc),
        .op_target  (op_target),
        .cond       (cond),
        .irq        (irq),
        .clr_err    (clr_err),
        .goto       (goto),
        .goto_addr  (goto_addr),
        .int_en     (int_en),
        .int_active (int_active),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // What the outputs must be this cycle, from the current inputs and model state.
    function automatic void predict(output bit g, output logic [11:0] a, output bit p_push,
                                    output bit p_pop, output bit p_int);
        bit live;
        logic [11:0] t;
        live   = op_valid && !kill;
        t      = (m_stk.size() > 0) ? m_stk[$] : 12'h000;
        g      = 1'b0;
        a      = 12'h000;
        p_push = 1'b0;
        p_pop  = 1'b0;
        p_int  = 1'b0;
        if (live) begin
            if (op_code == C_JUMP || op_code == C_CALL || (op_code == C_BRC && cond)) begin
                g = 1'b1;
                a = op_target;
            end
            if (op_code == C_CALL) p_push = 1'b1;
            if (op_code == C_RET || op_code == C_RETI) begin
                g     = 1'b1;
                a     = t;
                p_pop = 1'b1;
            end
            if (op_code == C_NONE && irq && m_ie && !m_ia) begin
                g      = 1'b1;
                a      = IVEC;
                p_push = 1'b1;
                p_int  = 1'b1;
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        bit g, pp, po, pi, oe, ue;
        logic [11:0] a, ret;
        if (reset) begin
            m_stk.delete();
            m_ie  = 1'b0;
            m_ia  = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            predict(g, a, pp, po, pi);
            oe = 1'b0;
            ue = 1'b0;
            if (!pause) begin
                ret = op_pc + 12'd1;
                if (pp) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(ret);
                    else oe = 1'b1;
                end
                if (po) begin
                    if (m_stk.size() > 0) void'(m_stk.pop_back());
                    else ue = 1'b1;
                end
                if (op_valid && !kill && op_code == C_EI) m_ie = 1'b1;
                if (op_valid && !kill && op_code == C_DI) m_ie = 1'b0;
                if (pi) m_ia = 1'b1;
                if (op_valid && !kill && op_code == C_RETI) m_ia = 1'b0;
            end
            m_ovf = oe || (m_ovf && !clr_err);
            m_unf = ue || (m_unf && !clr_err);
        end
    end

    always @(negedge clk) begin
        bit g, pp, po, pi;
        logic [11:0] a;
        if (cmp_en) begin
            predict(g, a, pp, po, pi);
            check("goto", {11'd0, goto}, {11'd0, g});
            if (g) check("goto_addr", goto_addr, a);
            check("int_en", {11'd0, int_en}, {11'd0, m_ie});
            check("int_active", {11'd0, int_active}, {11'd0, m_ia});
            check("stack_ovf", {11'd0, stack_ovf}, {11'd0, m_ovf});
            check("stack_unf", {11'd0, stack_unf}, {11'd0, m_unf});
        end
    end

    task automatic op(input logic [2:0] oc, input logic [11:0] pc, input logic [11:0] tgt);
        @(posedge clk);
        #2;
        op_valid  = 1'b1;
        op_code   = oc;
        op_pc     = pc;
        op_target = tgt;
    endtask

    task automatic lit(input string name, input logic [11:0] act, input logic [11:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        reset = 1'b1; pause = 1'b0; kill = 1'b0; op_valid = 1'b0; cond = 1'b0;
        irq = 1'b0; clr_err = 1'b0; op_code = C_NONE; op_pc = '0; op_target = '0;
        repeat (2) @(posedge clk);
        #1;
        lit("rst_int_en", {11'd0, int_en}, 12'd0);
        lit("rst_int_active", {11'd0, int_active}, 12'd0);
        lit("rst_ovf", {11'd0, stack_ovf}, 12'd0);
        lit("rst_unf", {11'd0, stack_unf}, 12'd0);
        cmp_en = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;

        // basic call / return
        op(C_CALL, 12'h010, 12'h100); #1;
        lit("call_goto", {11'd0, goto}, 12'd1);
        lit("call_addr", goto_addr, 12'h100);
        op(C_RET, 12'h100, 12'h000); #1;
        lit("ret_addr", goto_addr, 12'h011);
        op(C_RET, 12'h101, 12'h000); #1;
        lit("ret_empty_addr", goto_addr, 12'h000);
        op(C_NONE, 12'h102, 12'h000); #1;
        lit("unf_set", {11'd0, stack_unf}, 12'd1);
        op(C_NONE, 12'h103, 12'h000); clr_err = 1'b1;
        op(C_NONE, 12'h104, 12'h000); clr_err = 1'b0; #1;
        lit("unf_cleared", {11'd0, stack_unf}, 12'd0);

        // overflow then full drain in LIFO order
        for (int i = 0; i < 9; i++) op(C_CALL, 12'h100 + 12'(i), 12'h200);
        op(C_NONE, 12'h000, 12'h000); #1;
        lit("ovf_set", {11'd0, stack_ovf}, 12'd1);
        for (int i = 7; i >= 0; i--) begin
            op(C_RET, 12'h200, 12'h000); #1;
            lit("lifo_addr", goto_addr, 12'h101 + 12'(i));
        end
        op(C_RET, 12'h200, 12'h000); #1;
        lit("drain_unf_addr", goto_addr, 12'h000);
        op(C_NONE, 12'h000, 12'h000); #1;
        lit("drain_unf", {11'd0, stack_unf}, 12'd1);
        op(C_NONE, 12'h000, 12'h000); clr_err = 1'b1;
        op(C_NONE, 12'h000, 12'h000); clr_err = 1'b0;

        // interrupt entry and return
        op(C_EI, 12'h018, 12'h000);
        op(C_NONE, 12'h019, 12'h000); #1;
        lit("ei_set", {11'd0, int_en}, 12'd1);
        op(C_NONE, 12'h020, 12'h000); irq = 1'b1; #1;
        lit("int_goto", {11'd0, goto}, 12'd1);
        lit("int_addr", goto_addr, 12'h004);
        op(C_NONE, 12'h030, 12'h000); #1;
        lit("int_active_set", {11'd0, int_active}, 12'd1);
        lit("nested_irq_ignored", {11'd0, goto}, 12'd0);
        op(C_RETI, 12'h031, 12'h000); irq = 1'b0; #1;
        lit("reti_addr", goto_addr, 12'h021);
        op(C_NONE, 12'h022, 12'h000); #1;
        lit("int_active_clr", {11'd0, int_active}, 12'd0);

        // interrupt deferred behind a jump; killed slot does nothing
        op(C_JUMP, 12'h040, 12'h300); irq = 1'b1; #1;
        lit("jump_addr", goto_addr, 12'h300);
        op(C_NONE, 12'h300, 12'h000); #1;
        lit("deferred_int_addr", goto_addr, 12'h004);
        op(C_RETI, 12'h004, 12'h000); irq = 1'b0; #1;
        lit("deferred_reti", goto_addr, 12'h301);
        op(C_NONE, 12'h310, 12'h000); irq = 1'b1; kill = 1'b1; #1;
        lit("kill_goto", {11'd0, goto}, 12'd0);
        op(C_NONE, 12'h311, 12'h000); irq = 1'b0; kill = 1'b0; #1;
        lit("kill_no_int", {11'd0, int_active}, 12'd0);

        // paused call commits exactly once
        op(C_CALL, 12'h050, 12'h500); pause = 1'b1; #1;
        lit("pause_goto_addr", goto_addr, 12'h500);
        op(C_CALL, 12'h050, 12'h500);
        op(C_CALL, 12'h050, 12'h500);
        op(C_CALL, 12'h050, 12'h500); pause = 1'b0;
        op(C_RET, 12'h500, 12'h000); #1;
        lit("pause_ret", goto_addr, 12'h051);
        op(C_RET, 12'h501, 12'h000); #1;
        lit("pause_single_push", goto_addr, 12'h000);
        op(C_NONE, 12'h000, 12'h000); clr_err = 1'b1;
        op(C_NONE, 12'h000, 12'h000); clr_err = 1'b0;

        // wrap of return address; clr_err losing to a coincident overflow
        op(C_CALL, 12'hFFF, 12'h700);
        op(C_RET, 12'h700, 12'h000); #1;
        lit("wrap_ret", goto_addr, 12'h000);
        op(C_NONE, 12'h000, 12'h000); #1;
        lit("wrap_no_unf", {11'd0, stack_unf}, 12'd0);
        for (int i = 0; i < 8; i++) op(C_CALL, 12'h600 + 12'(i), 12'h700);
        op(C_CALL, 12'h608, 12'h700); clr_err = 1'b1;
        op(C_NONE, 12'h000, 12'h000); clr_err = 1'b0; #1;
        lit("ovf_beats_clr", {11'd0, stack_ovf}, 12'd1);

        // reset mid-operation empties the stack
        op(C_RET, 12'h700, 12'h000); #1;
        reset = 1'b1;
        op(C_NONE, 12'h000, 12'h000); reset = 1'b0; #1;
        lit("post_rst_ovf", {11'd0, stack_ovf}, 12'd0);
        op(C_RET, 12'h000, 12'h000); #1;
        lit("post_rst_ret", goto_addr, 12'h000);
        op(C_NONE, 12'h000, 12'h000); #1;
        lit("post_rst_unf", {11'd0, stack_unf}, 12'd1);

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            @(posedge clk);
            #2;
            reset     = ($urandom_range(0, 299) == 0);
            pause     = ($urandom_range(0, 99) < 15);
            kill      = ($urandom_range(0, 99) < 10);
            op_valid  = ($urandom_range(0, 99) < 90);
            op_code   = 3'($urandom_range(0, 7));
            op_pc     = ($urandom_range(0, 19) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
            op_target = 12'($urandom_range(0, 4095));
            cond      = 1'($urandom_range(0, 1));
            irq       = ($urandom_range(0, 99) < 30);
            clr_err   = ($urandom_range(0, 99) < 5);
        end
        @(posedge clk);
        #2;
        reset = 1'b0; op_valid = 1'b0; pause = 1'b0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, return-stack entries (power of 2, 2..16).
REQ-002 SHALL have parameter INT_VECTOR, default 12'h004, interrupt entry address.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port pause, input, 1, freezes all state updates when high.
REQ-006 SHALL have port kill, input, 1, the current op is squashed; treat as op_valid=0.
REQ-007 SHALL have port op_valid, input, 1, op_code/op_pc/op_target describe a live instruction.
REQ-008 SHALL have port op_code, input, 3, encoding: 0 NONE, 1 JUMP, 2 CALL, 3 RET, 4 BRCOND, 5 RETI, 6 EI, 7 DI.
REQ-009 SHALL have port op_pc, input, 12, address of the instruction carrying op_code.
REQ-010 SHALL have port op_target, input, 12, branch/call target address.
REQ-011 SHALL have port cond, input, 1, BRCOND taken when high.
REQ-012 SHALL have port irq, input, 1, level-sensitive interrupt request.
REQ-013 SHALL have port clr_err, input, 1, clears sticky error flags.
REQ-014 SHALL have port goto, output, 1, redirect request to pc_ctrl.
REQ-015 SHALL have port goto_addr, output, 12, redirect address to pc_ctrl.
REQ-016 SHALL have ports int_en, int_active, stack_ovf, stack_unf, output, 1 each, status.

Function
REQ-017 SHALL define live = op_valid & !kill; goto and goto_addr are combinational from live, op_code, cond, op_pc, op_target, irq and stack top, independent of pause.
REQ-018 SHALL, on live JUMP, or on live BRCOND with cond=1, drive goto=1 with goto_addr=op_target; BRCOND with cond=0 drives goto=0.
REQ-019 SHALL, on live CALL, drive goto=1 with goto_addr=op_target and push op_pc+1 (12-bit, wrapping 12'hFFF->12'h000).
REQ-020 SHALL, on live RET or RETI, drive goto=1 with goto_addr=top of stack and pop; RETI also clears int_active.
REQ-021 SHALL take an interrupt when live & op_code=NONE & irq & int_en & !int_active: goto=1, goto_addr=INT_VECTOR, push op_pc+1, set int_active; all other op codes defer the interrupt.
REQ-022 SHALL set int_en on live EI and clear it on live DI; goto=0 for EI, DI, NONE-without-interrupt.
REQ-023 SHALL, on push when full (STACK_DEPTH entries), still redirect, discard the pushed value, keep contents and pointer unchanged, and set sticky stack_ovf.
REQ-024 SHALL, on pop when empty, drive goto_addr=12'h000, keep pointer at 0, set sticky stack_unf; RETI still clears int_active.
REQ-025 SHALL update stack, pointer, int_en, int_active and sticky flags only on clock edges with pause=0; with pause=1 all state holds.
REQ-026 SHALL clear stack_ovf and stack_unf on clr_err (honoured even when pause=1); an error event in the same cycle as clr_err wins (flag set).
REQ-027 SHALL support a push or pop every cycle back-to-back with no bubble; no simultaneous push and pop occurs by construction.

Reset
REQ-028 SHALL, on reset high, asynchronously set stack pointer 0 (empty), int_en=0, int_active=0, stack_ovf=0, stack_unf=0; stack storage needs no reset.
REQ-029 SHALL, while reset is high, still compute goto/goto_addr combinationally, and pc_ctrl discards them during its own reset.
REQ-030 SHALL, on reset asserted mid-operation, abandon any pushed/popped state; the first post-reset pop underflows.

Structure
REQ-031 SHALL place op_code encodings, default STACK_DEPTH and INT_VECTOR in shared package branch_pkg.
REQ-032 SHALL implement storage as sub-module ret_stack (push, pop, push_data, top, full, empty; LIFO register array, async reset of pointer only).

Verification
REQ-033 SHALL cover: reset; CALL op_pc=12'h010 target=12'h100 -> goto=1, goto_addr=12'h100; then RET -> goto_addr=12'h011, stack empty.
REQ-034 SHALL cover: 9 consecutive CALLs with STACK_DEPTH=8 -> 9th sets stack_ovf=1; 8 RETs return the first 8 pushes in LIFO order; 9th RET -> goto_addr=12'h000, stack_unf=1.
REQ-035 SHALL cover: EI, irq=1, NONE at op_pc=12'h020 -> goto_addr=12'h004, int_active=1; second irq ignored; RETI -> goto_addr=12'h021, int_active=0.
REQ-036 SHALL cover: irq=1 with int_en=1 during a JUMP -> jump taken, interrupt taken on next live NONE; irq with kill=1 -> goto=0, no state change.
REQ-037 SHALL cover: CALL with pause=1 held 3 cycles -> stack pointer unchanged until the pause=0 edge, then exactly one push.
REQ-038 SHALL cover: CALL at op_pc=12'hFFF -> pushed 12'h000; clr_err coincident with overflow -> stack_ovf remains 1.
